// File: rtl/add_seq_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// add_seq_ctrl_pkg : shared defaults, op encoding and FSM state encoding
// Revision: 1.0
// =============================================================================
package add_seq_ctrl_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/add_seq_ctrl_pg_slice.sv
`default_nettype none
// =============================================================================
// pg_slice : SLICE-bit propagate/generate adder slice with full lookahead carry
// Revision: 1.0
// =============================================================================
module pg_slice
  import add_seq_ctrl_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_g;
  logic [SLICE:0]   w_c;

  assign w_p = x ^ y;
  assign w_g = x & y;

  // Each carry is expanded as a flat sum of generate terms, not rippled
  always_comb begin
    logic t;
    t   = 1'b0;
    w_c = '0;
    w_c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      t = cin;
      for (int j = 0; j <= i; j++) t = t & w_p[j];
      w_c[i+1] = t;
      for (int k = 0; k <= i; k++) begin
        t = w_g[k];
        for (int j = k + 1; j <= i; j++) t = t & w_p[j];
        w_c[i+1] = w_c[i+1] | t;
      end
    end
  end

  assign s     = w_p ^ w_c[SLICE-1:0];
  assign cout  = w_c[SLICE];
  assign c_msb = w_c[SLICE-1];

endmodule
`default_nettype wire

// File: rtl/add_seq_ctrl.sv
`default_nettype none
// =============================================================================
// add_seq_ctrl : sequential add/subtract, one SLICE-bit slice per RUN cycle
// Revision: 1.0
// =============================================================================
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [SLICE-1:0]   w_ssum;
  logic               w_scout;
  logic               w_cmsb;
  logic [WIDTH-1:0]   w_work_next;

  // Operands shift right each RUN cycle so the active slice is always at bit 0
  pg_slice #(
    .SLICE (SLICE)
  ) u_pg_slice (
    .x     (r_a[SLICE-1:0]),
    .y     (r_b[SLICE-1:0]),
    .cin   (r_carry),
    .s     (w_ssum),
    .cout  (w_scout),
    .c_msb (w_cmsb)
  );

  always_comb begin
    w_work_next = r_work;
    w_work_next[int'(r_idx) * SLICE +: SLICE] = w_ssum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_a     <= a;
            r_b     <= (op == OP_SUB) ? ~b : b;
            r_carry <= op;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> SLICE;
          r_b     <= r_b >> SLICE;
          r_carry <= w_scout;
          r_work  <= w_work_next;
          r_idx   <= r_idx + 1'b1;
          // Visible result only changes when the final slice lands
          if (r_idx == C_LAST_IDX) begin
            r_sum   <= w_work_next;
            r_cout  <= w_scout;
            r_ovf   <= w_cmsb ^ w_scout;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == ST_IDLE);
  assign res_valid   = (r_state == ST_DONE);
  assign busy        = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_add_seq_ctrl.sv
`default_nettype none
// =============================================================================
// tb_add_seq_ctrl : directed self-checking bench for add_seq_ctrl
// Revision: 1.0
// =============================================================================
module tb_add_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  add_seq_ctrl #(
    .WIDTH (16),
    .SLICE (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with res_ready high; expects the DUT to be in IDLE
  task automatic do_op(input string tag, input logic o, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] es,
                       input logic ec, input logic eo);
    int n;
    chk({tag, "_ready"}, start_ready, 1);
    op = o; a = x; b = y; start_valid = 1'b1; res_ready = 1'b1;
    tick();
    start_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    tick();
    chk({tag, "_idle"}, {busy, start_ready}, 2'b01);
    chk({tag, "_hold"}, sum, es);
  endtask

  logic [15:0] va [3];
  logic [15:0] vb [3];
  logic        vo [3];
  logic [15:0] ve [3];
  int          tacc [3];

  initial begin
    int n;
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0; op = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_outputs", {sum, cout, ovf, res_valid, busy}, 20'h0);
    #20;
    rst_n = 1'b1;
    tick();
    chk("rst_ready", start_ready, 1);

    do_op("add_basic", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
    do_op("add_wrap",  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    do_op("sub_neg",   1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",   1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub_pos",   1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
    do_op("add_mm",    1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);

    // Stall in DONE with garbage on the request side
    op = 1'b0; a = 16'h00FF; b = 16'h0F01; start_valid = 1'b1; res_ready = 1'b0;
    tick();
    start_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk("stall_latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      a = 16'hA5A5 ^ 16'(i); b = ~a; op = i[0]; start_valid = 1'b1;
      tick();
      chk("stall_valid", res_valid, 1);
      chk("stall_sum", sum, 16'h1000);
      chk("stall_ready", start_ready, 0);
    end
    start_valid = 1'b0; res_ready = 1'b1;
    tick();
    chk("stall_release", {busy, start_ready, res_valid}, 3'b010);
    chk("stall_keep", sum, 16'h1000);

    // Reset in the second RUN cycle
    op = 1'b0; a = 16'h1111; b = 16'h2222; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {sum, cout, ovf, res_valid, busy, start_ready}, 21'h1);
    #2;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid || busy) n++;
    end
    chk("mid_no_result", n, 0);
    do_op("post_rst", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    // Back-to-back with start_valid and res_ready held high
    va[0] = 16'h0010; vb[0] = 16'h0020; vo[0] = 1'b0; ve[0] = 16'h0030;
    va[1] = 16'h0100; vb[1] = 16'h0001; vo[1] = 1'b1; ve[1] = 16'h00FF;
    va[2] = 16'hABCD; vb[2] = 16'h1111; vo[2] = 1'b0; ve[2] = 16'hBCDE;
    a = va[0]; b = vb[0]; op = vo[0]; start_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!busy && n < 20);
      chk("b2b_accept", busy, 1);
      tacc[i] = cyc;
      if (i < 2) begin
        a = va[i+1]; b = vb[i+1]; op = vo[i+1];
      end else begin
        start_valid = 1'b0;
      end
      n = 0;
      while (!res_valid && n < 20) begin
        tick();
        n++;
      end
      chk("b2b_sum", sum, ve[i]);
      if (i > 0) chk("b2b_spacing", tacc[i] - tacc[i-1], 6);
    end
    tick();
    chk("b2b_end", {busy, start_ready}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
